// File: rtl/rtc_rd_seq_pkg.sv
// Shared RTC bus definitions: register address map, sequencer state encoding
// and default strobe timing, used by both the read and write paths.
package rtc_rd_seq_pkg;

  localparam int T_PULSE_DEF = 10;
  localparam int T_GAP_DEF   = 5;
  localparam int N_REGS      = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_REL = 3'd2,
    DATA     = 3'd3,
    DATA_REL = 3'd4,
    DONE     = 3'd5
  } rd_state_e;

  // Bank index -> RTC register address (clock block, then timer block).
  function automatic logic [7:0] rtc_reg_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Down-counter timing each bus phase: loaded with (length-1) on phase entry,
// o_done is high on the final cycle of the phase.
module rtc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_count,
  output logic         o_done,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/rtc_rd_seq.sv
// Sweeps the nine RTC time/timer registers over the multiplexed bus into a
// local bank that the VGA stage reads combinationally.
module rtc_rd_seq
  import rtc_rd_seq_pkg::*;
#(
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       CSR,
  output logic       RDR,
  output logic       WRR,
  output logic       ADR,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  input  logic [3:0] vga_sel,
  output logic [7:0] vga_data,
  output logic       fin_rd,
  output logic [2:0] o_dbg_state
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

  rd_state_e  r_state;
  rd_state_e  w_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [7:0] r_bank [N_REGS];

  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_done;
  logic [CW-1:0] w_cnt;

  logic       r_csr, r_rdr, r_wrr, r_adr, r_oe, r_fin;
  logic [7:0] r_ad_out;
  logic       w_csr, w_rdr, w_wrr, w_adr, w_oe, w_fin;
  logic [7:0] w_ad_out;
  logic [7:0] w_vga;

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_count    (1'b1),
    .o_done     (w_done),
    .o_cnt      (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // en is only sampled between transactions, so a started read always completes.
  always_comb begin
    w_nxt     = r_state;
    w_idx_nxt = r_idx;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (en) w_nxt = ADDR;
      end
      ADDR:     if (w_done) w_nxt = ADDR_REL;
      ADDR_REL: if (w_done) w_nxt = DATA;
      DATA:     if (w_done) w_nxt = DATA_REL;
      DATA_REL: begin
        if (w_done) begin
          if (r_idx == LAST_IDX) begin
            w_nxt = DONE;
          end else if (!en) begin
            w_nxt     = IDLE;
            w_idx_nxt = '0;
          end else begin
            w_nxt     = ADDR;
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      // DONE doubles as the inter-sweep idle cycle, giving a 271-cycle period.
      DONE: begin
        w_idx_nxt = '0;
        w_nxt     = en ? ADDR : IDLE;
      end
      default: begin
        w_nxt     = IDLE;
        w_idx_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_load     = (w_nxt != r_state);
    w_load_val = '0;
    case (w_nxt)
      ADDR, DATA:         w_load_val = CW'(T_PULSE - 1);
      ADDR_REL, DATA_REL: w_load_val = CW'(T_GAP - 1);
      default:            w_load_val = '0;
    endcase
  end

  // Bus outputs are decoded from the next state and registered.
  always_comb begin
    w_csr    = 1'b1;
    w_rdr    = 1'b1;
    w_wrr    = 1'b1;
    w_adr    = 1'b1;
    w_oe     = 1'b0;
    w_fin    = 1'b0;
    w_ad_out = 8'h00;
    case (w_nxt)
      ADDR: begin
        w_csr    = 1'b0;
        w_wrr    = 1'b0;
        w_adr    = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = rtc_reg_addr(w_idx_nxt);
      end
      ADDR_REL: begin
        w_adr    = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = rtc_reg_addr(w_idx_nxt);
      end
      DATA: begin
        w_csr = 1'b0;
        w_rdr = 1'b0;
      end
      DONE:    w_fin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csr    <= 1'b1;
      r_rdr    <= 1'b1;
      r_wrr    <= 1'b1;
      r_adr    <= 1'b1;
      r_oe     <= 1'b0;
      r_fin    <= 1'b0;
      r_ad_out <= 8'h00;
    end else begin
      r_csr    <= w_csr;
      r_rdr    <= w_rdr;
      r_wrr    <= w_wrr;
      r_adr    <= w_adr;
      r_oe     <= w_oe;
      r_fin    <= w_fin;
      r_ad_out <= w_ad_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) r_bank[i] <= 8'h00;
    end else if ((r_state == DATA) && w_done) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (r_idx == 4'(i)) r_bank[i] <= ad_in;
      end
    end
  end

  always_comb begin
    w_vga = 8'h00;
    for (int i = 0; i < N_REGS; i++) begin
      if (vga_sel == 4'(i)) w_vga = r_bank[i];
    end
  end

  assign CSR         = r_csr;
  assign RDR         = r_rdr;
  assign WRR         = r_wrr;
  assign ADR         = r_adr;
  assign ad_oe       = r_oe;
  assign ad_out      = r_ad_out;
  assign fin_rd      = r_fin;
  assign vga_data    = w_vga;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rtc_rd_seq.sv
// Directed bench for rtc_rd_seq with a small RTC model that answers each read
// with the latched register address plus 0x10.
module tb_rtc_rd_seq;
  import rtc_rd_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ad_in;
  logic [3:0] vga_sel;
  logic       CSR, RDR, WRR, ADR, ad_oe, fin_rd;
  logic [7:0] ad_out, vga_data;
  logic [2:0] o_dbg_state;
  logic [7:0] r_lat_addr = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_full [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h51, 8'h52, 8'h53};
  logic [7:0] exp_part [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_zero [9] = '{default: 8'h00};

  // Clock and reset-free clock generator
  always #5 clk = ~clk;

  // RTC model: address latched while CS and WR are low
  always @(posedge clk) begin
    if (!CSR && !WRR) r_lat_addr <= ad_out;
  end
  assign ad_in = r_lat_addr + 8'h10;

  rtc_rd_seq dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .CSR         (CSR),
    .RDR         (RDR),
    .WRR         (WRR),
    .ADR         (ADR),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .ad_in       (ad_in),
    .vga_sel     (vga_sel),
    .vga_data    (vga_data),
    .fin_rd      (fin_rd),
    .o_dbg_state (o_dbg_state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_bank(input string tag, input logic [7:0] exp [9]);
    for (int i = 0; i < 9; i++) begin
      vga_sel = 4'(i);
      #1;
      check($sformatf("%s_bank%0d", tag, i), vga_data, exp[i]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    vga_sel = 4'd0;

    // Reset state
    cyc(2);
    check("rst_csr", 8'(CSR), 8'h01);
    check("rst_rdr", 8'(RDR), 8'h01);
    check("rst_wrr", 8'(WRR), 8'h01);
    check("rst_adr", 8'(ADR), 8'h01);
    check("rst_oe", 8'(ad_oe), 8'h00);
    check("rst_adout", ad_out, 8'h00);
    check("rst_fin", 8'(fin_rd), 8'h00);
    check("rst_state", 8'(o_dbg_state), 8'(IDLE));
    check_bank("rst", exp_zero);

    rst = 1'b0;
    cyc(3);
    check("idle_en0_csr", 8'(CSR), 8'h01);
    check("idle_en0_oe", 8'(ad_oe), 8'h00);

    // Two back-to-back sweeps with en held high; k counts cycles from the first ADDR
    vga_sel = 4'd12;
    en      = 1'b1;
    for (int k = 1; k <= 560; k++) begin
      @(negedge clk);
      if (k <= 30) begin
        check($sformatf("t0_wrr_k%0d", k), 8'(WRR), (k <= 10) ? 8'h00 : 8'h01);
        check($sformatf("t0_rdr_k%0d", k), 8'(RDR), (k >= 16 && k <= 25) ? 8'h00 : 8'h01);
        check($sformatf("t0_csr_k%0d", k), 8'(CSR),
              (k <= 10 || (k >= 16 && k <= 25)) ? 8'h00 : 8'h01);
        check($sformatf("t0_oe_k%0d", k), 8'(ad_oe), (k <= 15) ? 8'h01 : 8'h00);
        if (k <= 25) check($sformatf("t0_adr_k%0d", k), 8'(ADR), (k <= 15) ? 8'h00 : 8'h01);
        if (k <= 15) check($sformatf("t0_adout_k%0d", k), ad_out, 8'h21);
      end
      check($sformatf("fin_k%0d", k), 8'(fin_rd), (k == 271 || k == 542) ? 8'h01 : 8'h00);
      check($sformatf("rw_excl_k%0d", k), 8'(RDR | WRR), 8'h01);
      check($sformatf("oe_rd_k%0d", k), 8'(ad_oe & ~RDR), 8'h00);
      check($sformatf("vga12_k%0d", k), vga_data, 8'h00);
    end
    check_bank("sweep", exp_full);

    // en dropped during index 3 ADDR
    en  = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (k == 95) en = 1'b0;
      check($sformatf("drop_fin_k%0d", k), 8'(fin_rd), 8'h00);
      if (k >= 121) begin
        check($sformatf("drop_csr_k%0d", k), 8'(CSR), 8'h01);
        check($sformatf("drop_oe_k%0d", k), 8'(ad_oe), 8'h00);
      end
    end
    check("drop_state", 8'(o_dbg_state), 8'(IDLE));
    check_bank("drop", exp_part);

    // Reset in the middle of index 5 DATA
    vga_sel = 4'd0;
    rst     = 1'b1;
    cyc(1);
    rst = 1'b0;
    en  = 1'b1;
    cyc(170);
    check("mid5_rdr", 8'(RDR), 8'h00);
    check("mid5_bank4", 8'h35, 8'h35);
    vga_sel = 4'd4;
    #1;
    check("mid5_bank4_live", vga_data, 8'h35);
    rst = 1'b1;
    #1;
    check("arst_csr", 8'(CSR), 8'h01);
    check("arst_rdr", 8'(RDR), 8'h01);
    check("arst_wrr", 8'(WRR), 8'h01);
    check("arst_oe", 8'(ad_oe), 8'h00);
    check("arst_fin", 8'(fin_rd), 8'h00);
    check_bank("arst", exp_zero);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_wrr", 8'(WRR), 8'h00);
    check("restart_csr", 8'(CSR), 8'h00);
    check("restart_adr", 8'(ADR), 8'h00);
    check("restart_adout", ad_out, 8'h21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_rd_seq.md
RTC_RD_SEQ -- requirements
Module: rtc_rd_seq

Interface
REQ-001 SHALL have parameter T_PULSE, default 10, clock cycles per asserted strobe phase (address latch, read).
REQ-002 SHALL have parameter T_GAP, default 5, clock cycles of bus-idle recovery after each strobe phase.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, sweep enable from the general FSM.
REQ-006 SHALL have port CSR, output, 1, RTC chip select, active low.
REQ-007 SHALL have port RDR, output, 1, RTC read strobe, active low.
REQ-008 SHALL have port WRR, output, 1, RTC write strobe, active low; used only to latch the address.
REQ-009 SHALL have port ADR, output, 1, address/data select: 0 = address phase, 1 = data phase.
REQ-010 SHALL have port ad_out, output, 8, register address driven onto the multiplexed bus.
REQ-011 SHALL have port ad_oe, output, 1, bus-driver enable; 1 only while ad_out is valid.
REQ-012 SHALL have port ad_in, input, 8, data returned by the RTC.
REQ-013 SHALL have port vga_sel, input, 4, bank index 0..8 requested by the VGA stage.
REQ-014 SHALL have port vga_data, output, 8, bank content at vga_sel, combinational.
REQ-015 SHALL have port fin_rd, output, 1, one-cycle pulse marking a completed nine-register sweep.

Function
REQ-016 SHALL read nine RTC registers in index order 0..8 at addresses 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 timer-sec, 0x42 timer-min, 0x43 timer-hour.
REQ-017 SHALL use the states IDLE, ADDR, ADDR_REL, DATA, DATA_REL and DONE.
REQ-018 IDLE: CSR/RDR/WRR=1, ADR=1, ad_oe=0, index=0; go to ADDR on the next edge when en=1.
REQ-019 ADDR, T_PULSE cycles: CSR=0, WRR=0, ADR=0, ad_oe=1, ad_out=address[index].
REQ-020 ADDR_REL, T_GAP cycles: CSR=WRR=1, ADR=0, ad_oe=1, ad_out held for address hold time.
REQ-021 DATA, T_PULSE cycles: CSR=0, RDR=0, ADR=1, ad_oe=0; ad_in is captured into bank[index] on the last DATA cycle only.
REQ-022 DATA_REL, T_GAP cycles: all strobes high, ad_oe=0; then: index==8 -> DONE; en==0 -> IDLE; else index+1 -> ADDR.
REQ-023 DONE: fin_rd=1 for exactly one cycle, then IDLE; with en still 1, a new sweep starts one cycle later.
REQ-024 Phase timing SHALL come from one down-counter of width clog2(max(T_PULSE,T_GAP)+1), loaded on each state entry.
REQ-025 Per-register transaction SHALL take 2*T_PULSE+2*T_GAP cycles (30 at defaults); a full sweep SHALL take 270 cycles plus DONE.
REQ-026 When en falls mid-transaction, the current transaction SHALL finish through DATA_REL (capture included), return to IDLE, and not pulse fin_rd; the next sweep restarts at index 0.
REQ-027 RDR and WRR SHALL never be 0 in the same cycle; ad_oe SHALL never be 1 while RDR=0.
REQ-028 vga_sel values 9..15 SHALL return 0x00; bank reads SHALL not disturb the sweep.
REQ-029 All bus outputs SHALL be registered (glitch-free).

Reset
REQ-030 rst=1 SHALL immediately force IDLE, counter=0, index=0, CSR=RDR=WRR=1, ADR=1, ad_oe=0, ad_out=0x00, fin_rd=0 and all bank entries 0x00, regardless of state.
REQ-031 After rst falls, the first ADDR cycle SHALL occur on the first edge at which en=1.

Structure
REQ-032 The address table (nine 8-bit constants), state encoding, and T_PULSE/T_GAP defaults SHALL live in a shared package used by the write path too.
REQ-033 The bus strobe/phase timer SHALL be one sub-module, rtc_phase_timer (load, count, done); the bank and FSM stay in rtc_rd_seq.

Verification
REQ-034 Reset then en=1 with the RTC model returning address+0x10 -> after 270 cycles a one-cycle fin_rd pulse; bank = 0x31,0x32,0x33,0x34,0x35,0x36,0x51,0x52,0x53.
REQ-035 Strobe timing check on index 0 -> WRR low exactly 10 cycles with ad_out=0x21 and ADR=0; 5 idle cycles; RDR low exactly 10 cycles with ADR=1 and ad_oe=0.
REQ-036 en dropped during index 3 ADDR -> index 3 is still captured (0x34); CS stays high afterwards; no fin_rd pulse; bank[4..8] are unchanged.
REQ-037 rst asserted mid-DATA of index 5 -> in the same cycle all strobes=1, ad_oe=0, bank all 0x00; after release with en=1, the sweep restarts at 0x21.
REQ-038 en held high for two sweeps -> fin_rd pulses are exactly 271 cycles apart; vga_sel=12 reads 0x00 throughout.
